// File: rtl/systolic_pkg.sv
// Shared width and lane helpers for the systolic drain collector.
// DRAIN_SAT_EN selects saturating 2*dataSize-bit output lanes; otherwise lanes keep the full p_sum width.
package systolic_pkg;

    function automatic int psum_w(input int data_size);
        return 2 * data_size + 2;
    endfunction

    function automatic int lane_w(input int data_size);
`ifdef DRAIN_SAT_EN
        return 2 * data_size;
`else
        return 2 * data_size + 2;
`endif
    endfunction

    // Width of a counter over n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [63:0] sat_lane(input logic [63:0] v, input int data_size);
        logic [63:0] mask;
        mask = (64'd1 << (2 * data_size)) - 64'd1;
        return ((v & ~mask) != 64'd0) ? mask : (v & mask);
    endfunction

endpackage

// File: rtl/systolic_drain_if.sv
// Array-side and stream-side signals of the systolic drain collector.
// With DRAIN_SAT_EN defined the m_data lanes narrow to 2*dataSize bits.
interface systolic_drain_if
    import systolic_pkg::*;
#(
    parameter int dataSize = 8,
    parameter int COLS     = 4
);
    localparam int PSUM_W = psum_w(dataSize);
    localparam int LANE_W = lane_w(dataSize);

    logic                     en;
    logic                     s_valid;
    logic [COLS*PSUM_W-1:0]   col_psum;

    // A row transfers on each rising edge with m_valid && m_ready; m_data/m_last hold while m_valid && !m_ready.
    logic                     m_valid;
    logic                     m_ready;
    logic [COLS*LANE_W-1:0]   m_data;
    logic                     m_last;
    logic                     stall;
    logic                     overflow;

    modport master (
        input  en, s_valid, col_psum, m_ready,
        output m_valid, m_data, m_last, stall, overflow
    );

    modport slave (
        output en, s_valid, col_psum, m_ready,
        input  m_valid, m_data, m_last, stall, overflow
    );
endinterface

// File: rtl/drain_row_fifo.sv
// Synchronous first-word fall-through FIFO holding deskewed result rows.
// A push into a full FIFO is taken only when a pop frees the slot in the same cycle.
module drain_row_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) wptr_d = wptr_q + AW'(1);
        if (pop_ok)  rptr_d = rptr_q + AW'(1);
        if (push_ok && !pop_ok)      cnt_d = cnt_q + CW'(1);
        else if (pop_ok && !push_ok) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/systolic_drain.sv
// Deskews bottom-row p_sums into aligned rows, buffers them and streams them out with tile framing.
// DRAIN_SAT_EN saturates each output lane to 2*dataSize bits on the FIFO read side.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int dataSize   = 8,
    parameter int COLS       = 4,
    parameter int ROWS       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input logic              clk,
    input logic              rst,
    systolic_drain_if.master bus
);
    localparam int PSUM_W = psum_w(dataSize);
    localparam int LANE_W = lane_w(dataSize);
    localparam int RW     = COLS * PSUM_W;
    localparam int CW     = cnt_w(ROWS);
    localparam int FCW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

    logic [RW-1:0]   aligned;
    logic [COLS-2:0] vpipe_q;
    logic [RW-1:0]   row_q;
    logic            row_vld_q;
    logic [CW-1:0]   row_cnt_q, row_cnt_d;
    logic            ovf_q, ovf_d;
    logic            push_req, push, pop, row_is_last;
    logic [RW:0]     fifo_rdata;
    logic            fifo_empty, fifo_full;
    logic [FCW-1:0]  fifo_count;

    // Column j arrives j cycles after column 0, so it waits COLS-1-j en-cycles.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int D = COLS - 1 - j;
        if (D == 0) begin : g_direct
            assign aligned[j*PSUM_W +: PSUM_W] = bus.col_psum[j*PSUM_W +: PSUM_W];
        end else begin : g_line
            logic [PSUM_W-1:0] line_q [D];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < D; k++) line_q[k] <= '0;
                end else if (bus.en) begin
                    line_q[0] <= bus.col_psum[j*PSUM_W +: PSUM_W];
                    for (int k = 1; k < D; k++) line_q[k] <= line_q[k-1];
                end
            end
            assign aligned[j*PSUM_W +: PSUM_W] = line_q[D-1];
        end
    end

    assign push_req    = bus.en && row_vld_q;
    assign pop         = !fifo_empty && bus.m_ready;
    assign push        = push_req && (!fifo_full || pop);
    assign row_is_last = (row_cnt_q == LAST_ROW);

    // Dropped rows still advance the tile counter so m_last stays on tile boundaries.
    always_comb begin
        row_cnt_d = row_cnt_q;
        ovf_d     = ovf_q;
        if (push_req) begin
            row_cnt_d = row_is_last ? '0 : row_cnt_q + CW'(1);
            if (!push) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vpipe_q   <= '0;
            row_q     <= '0;
            row_vld_q <= 1'b0;
            row_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            row_cnt_q <= row_cnt_d;
            ovf_q     <= ovf_d;
            if (bus.en) begin
                vpipe_q[0] <= bus.s_valid;
                for (int k = 1; k < COLS - 1; k++) vpipe_q[k] <= vpipe_q[k-1];
                row_q     <= aligned;
                row_vld_q <= vpipe_q[COLS-2];
            end
        end
    end

    drain_row_fifo #(
        .W     (RW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({row_is_last, row_q}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    for (genvar j = 0; j < COLS; j++) begin : g_lane
        logic [PSUM_W-1:0] raw;
        logic [LANE_W-1:0] lane;
        assign raw = fifo_rdata[j*PSUM_W +: PSUM_W];
`ifdef DRAIN_SAT_EN
        assign lane = LANE_W'(sat_lane(64'(raw), dataSize));
`else
        assign lane = raw;
`endif
        assign bus.m_data[j*LANE_W +: LANE_W] = fifo_empty ? '0 : lane;
    end

    assign bus.m_valid  = !fifo_empty;
    assign bus.m_last   = !fifo_empty && fifo_rdata[RW];
    assign bus.overflow = ovf_q;
    // Worst case the skew pipe still holds COLS rows when stall rises.
    assign bus.stall    = (FIFO_DEPTH[FCW-1:0] - fifo_count) <= COLS[FCW-1:0];
endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain: skewed row injection, row-level reference model, scoreboard.
// Works with or without DRAIN_SAT_EN.
module tb_systolic_drain;
    localparam int DS         = 8;
    localparam int COLS       = 4;
    localparam int ROWS       = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int PSUM_W     = 2 * DS + 2;
`ifdef DRAIN_SAT_EN
    localparam int LANE_W = 2 * DS;
    localparam int unsigned LANE_MAX = (1 << LANE_W) - 1;
    localparam logic [LANE_W-1:0] EXP_L0 = 16'hFFFF;
    localparam logic [LANE_W-1:0] EXP_L1 = 16'hFFFE;
`else
    localparam int LANE_W = 2 * DS + 2;
    localparam logic [LANE_W-1:0] EXP_L0 = 18'h10000;
    localparam logic [LANE_W-1:0] EXP_L1 = 18'h0FFFE;
`endif
    localparam int OW = COLS * LANE_W + 1;

    typedef logic [COLS-1:0][PSUM_W-1:0] row_t;
    typedef struct { int start; row_t v; } inj_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ec       = 0;
    int   tile     = 0;
    int   first_vld = -1;
    inj_t inj_q[$];
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] got_q[$];

    systolic_drain_if #(.dataSize(DS), .COLS(COLS)) bus ();

    systolic_drain #(
        .dataSize   (DS),
        .COLS       (COLS),
        .ROWS       (ROWS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [COLS*LANE_W-1:0] model_row(input row_t v);
        logic [COLS*LANE_W-1:0] r;
        for (int j = 0; j < COLS; j++) begin
            int unsigned x;
            x = 32'(v[j]);
`ifdef DRAIN_SAT_EN
            if (x > LANE_MAX) x = LANE_MAX;
`endif
            r[j*LANE_W +: LANE_W] = LANE_W'(x);
        end
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t v;
        for (int j = 0; j < COLS; j++) v[j] = PSUM_W'($urandom);
        return v;
    endfunction

    // Row model: each injected row advances the tile position; dropped rows are never expected.
    task automatic inject(input int start, input row_t v, input bit drop);
        inj_t e;
        e.start = start;
        e.v     = v;
        inj_q.push_back(e);
        if (!drop) exp_q.push_back({tile == ROWS - 1, model_row(v)});
        tile = (tile + 1) % ROWS;
    endtask

    // One clock: drive skewed columns for en-cycle ec, record any accepted output row.
    task automatic step(input logic en_v, input logic rdy_v, input logic obey);
        logic [COLS*PSUM_W-1:0] cols;
        logic sv;
        logic en_eff;
        @(negedge clk);
        cyc++;
        if (bus.m_valid === 1'b1 && first_vld < 0) first_vld = cyc;
        en_eff = en_v && !(obey && bus.stall);
        sv = en_eff ? 1'b0 : 1'($urandom_range(0, 1));
        for (int j = 0; j < COLS; j++) cols[j*PSUM_W +: PSUM_W] = PSUM_W'($urandom);
        if (en_eff) begin
            foreach (inj_q[i]) begin
                if (inj_q[i].start == ec) sv = 1'b1;
                for (int j = 0; j < COLS; j++)
                    if (inj_q[i].start + j == ec) cols[j*PSUM_W +: PSUM_W] = inj_q[i].v[j];
            end
        end
        bus.en       = en_eff;
        bus.s_valid  = sv;
        bus.col_psum = cols;
        bus.m_ready  = rdy_v;
        if (bus.m_valid === 1'b1 && rdy_v) got_q.push_back({bus.m_last, bus.m_data});
        if (en_eff) ec++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        inj_q.delete();
        exp_q.delete();
        got_q.delete();
        tile      = 0;
        first_vld = -1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
        checks++; if (bus.m_data !== '0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", bus.m_data); end
        checks++; if (bus.m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b exp=0", bus.m_last); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_single_row();
        row_t v;
        int base_c;
        logic [OW-1:0] want, got;
        do_reset();
        for (int j = 0; j < COLS; j++) v[j] = PSUM_W'(10 + j);
        base_c = cyc + 1;
        inject(ec, v, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
        want = {1'b0, LANE_W'(13), LANE_W'(12), LANE_W'(11), LANE_W'(10)};
        got  = (got_q.size() > 0) ? got_q[0] : 'x;
        checks++; if (first_vld !== base_c + 5) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", first_vld - base_c, 5); end
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
        checks++; if (got !== want) begin failures++; $display("FAIL single_row got=%h exp=%h", got, want); end
    endtask

    task automatic test_full_tile();
        int s0;
        do_reset();
        s0 = ec;
        for (int i = 0; i < 2 * ROWS; i++) inject(s0 + i, rand_row(), 1'b0);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL tile_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL tile_row[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
            checks++; if (got_q[i][OW-1] !== (i % ROWS == ROWS - 1)) begin failures++; $display("FAIL tile_last[%0d] got=%b", i, got_q[i][OW-1]); end
        end
    endtask

    task automatic test_en_gap();
        int base_c;
        logic [OW-1:0] got;
        do_reset();
        base_c = cyc + 1;
        inject(ec, rand_row(), 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0);
        got = (got_q.size() > 0) ? got_q[0] : 'x;
        checks++; if (first_vld !== base_c + 8) begin failures++; $display("FAIL en_gap_latency got=%0d exp=%0d", first_vld - base_c, 8); end
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL en_gap_count got=%0d exp=1", got_q.size()); end
        checks++; if (got !== exp_q[0]) begin failures++; $display("FAIL en_gap_row got=%h exp=%h", got, exp_q[0]); end
    endtask

    task automatic test_overflow();
        int base_c, s0, n;
        do_reset();
        base_c = cyc + 1;
        s0 = ec;
        for (int i = 0; i <= FIFO_DEPTH; i++) inject(s0 + i, rand_row(), i == FIFO_DEPTH);
        for (int s = 0; s < 20; s++) begin
            step(1'b1, 1'b0, 1'b0);
            n = 0;
            for (int i = 0; i <= FIFO_DEPTH; i++) if (base_c + i + 5 <= cyc) n++;
            if (n > FIFO_DEPTH) n = FIFO_DEPTH;
            checks++; if (bus.stall !== ((FIFO_DEPTH - n) <= COLS)) begin failures++; $display("FAIL ovf_stall cyc=%0d rows=%0d got=%b", cyc - base_c, n, bus.stall); end
            checks++; if (bus.overflow !== (cyc >= base_c + 13)) begin failures++; $display("FAIL ovf_flag cyc=%0d got=%b", cyc - base_c, bus.overflow); end
            if (n > 0) begin
                checks++; if ({bus.m_last, bus.m_data} !== exp_q[0]) begin failures++; $display("FAIL ovf_hold got=%h exp=%h", {bus.m_last, bus.m_data}, exp_q[0]); end
            end
        end
        for (int s = 0; s < 40 && got_q.size() < FIFO_DEPTH; s++) step(1'b1, 1'b1, 1'b0);
        s0 = ec;
        for (int i = 0; i < 3; i++) inject(s0 + i, rand_row(), 1'b0);
        for (int s = 0; s < 15; s++) step(1'b1, 1'b1, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_row[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    endtask

    task automatic test_saturation();
        row_t v;
        logic [OW-1:0] got;
        do_reset();
        v[0] = 18'h10000;
        v[1] = 18'h0FFFE;
        v[2] = 18'h3FFFF;
        v[3] = 18'h00000;
        inject(ec, v, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
        got = (got_q.size() > 0) ? got_q[0] : 'x;
        checks++; if (got[LANE_W-1:0] !== EXP_L0) begin failures++; $display("FAIL sat_lane0 got=%h exp=%h", got[LANE_W-1:0], EXP_L0); end
        checks++; if (got[2*LANE_W-1:LANE_W] !== EXP_L1) begin failures++; $display("FAIL sat_lane1 got=%h exp=%h", got[2*LANE_W-1:LANE_W], EXP_L1); end
        checks++; if (got !== exp_q[0]) begin failures++; $display("FAIL sat_row got=%h exp=%h", got, exp_q[0]); end
    endtask

    task automatic test_back_to_back();
        int nxt;
        do_reset();
        nxt = ec + 1;
        for (int i = 0; i < 40; i++) begin
            inject(nxt, rand_row(), 1'b0);
            nxt += $urandom_range(1, 3);
        end
        for (int s = 0; s < 3000 && got_q.size() < 40; s++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b1);
        for (int s = 0; s < 10; s++) step(1'b1, 1'b1, 1'b1);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_row[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_reset_midflight();
        int s0;
        do_reset();
        s0 = ec;
        for (int i = 0; i < 5; i++) inject(s0 + i, rand_row(), 1'b0);
        for (int s = 0; s < 8; s++) step(1'b1, 1'b0, 1'b0);
        checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%b exp=1", bus.m_valid); end
        inj_q.delete();
        exp_q.delete();
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        first_vld = -1;
        got_q.delete();
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.m_valid); end
        checks++; if (bus.m_data !== '0) begin failures++; $display("FAIL midrst_data got=%h exp=0", bus.m_data); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow got=%b exp=0", bus.overflow); end
        for (int s = 0; s < 20; s++) step(1'b1, 1'b1, 1'b0);
        checks++; if (first_vld !== -1) begin failures++; $display("FAIL midrst_stale got_valid_at=%0d exp=none", first_vld); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL midrst_rows got=%0d exp=0", got_q.size()); end
    endtask

    initial begin
        rst          = 1'b0;
        bus.en       = 1'b0;
        bus.s_valid  = 1'b0;
        bus.col_psum = '0;
        bus.m_ready  = 1'b0;
        test_reset();
        test_single_row();
        test_full_tile();
        test_en_gap();
        test_overflow();
        test_saturation();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
